// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time-keeping core and the display stage.
// Digit indices here must stay aligned with the display's blink selection.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [3:0] ONES_MAX = 4'd9;

endpackage

// File: rtl/mod_digit_counter.sv
// One BCD digit: wraps at MAX, carry-out flags an enabled wrap.
module mod_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    // A glitched value above MAX restarts at 0 on its next increment.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (en) begin
            value_d = (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = en & (value_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch mm:ss core: run/pause/adjust control over four BCD digit counters.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] SEC_TENS_MAX  = 4'd5,
    parameter logic [3:0] MIN_TENS_MAX  = 4'd5,
    parameter bit         START_RUNNING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_p,
    input  logic       clr_p,
    input  logic       adj,
    input  logic [1:0] adj_sel,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    localparam state_t RESET_STATE = START_RUNNING ? ST_RUN : ST_PAUSED;

    state_t state_q, state_d;
    state_t resume_q, resume_d;
    logic   rollover_q, rollover_d;

    logic run_adv, adj_adv;
    logic en_so, en_st, en_mo, en_mt;
    logic carry_so, carry_st, carry_mo, carry_mt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            resume_q   <= RESET_STATE;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            rollover_q <= rollover_d;
        end
    end

    // A clear holds the state; adj entry has priority over pause_p.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        if (!clr_p) begin
            case (state_q)
                ST_RUN: begin
                    if (adj) begin
                        state_d  = ST_ADJUST;
                        resume_d = ST_RUN;
                    end else if (pause_p) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (adj) begin
                        state_d  = ST_ADJUST;
                        resume_d = ST_PAUSED;
                    end else if (pause_p) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ADJUST: begin
                    if (!adj) begin
                        state_d = resume_q;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    // RUN uses the carry chain; ADJUST bumps only the selected digit.
    always_comb begin
        run_adv = (state_q == ST_RUN) && !adj && tick_1hz && !clr_p;
        adj_adv = (state_q == ST_ADJUST) && adj && tick_2hz && !clr_p;
        en_so   = run_adv | (adj_adv && (adj_sel == DIG_SEC_ONES));
        en_st   = run_adv ? carry_so : (adj_adv && (adj_sel == DIG_SEC_TENS));
        en_mo   = run_adv ? carry_st : (adj_adv && (adj_sel == DIG_MIN_ONES));
        en_mt   = run_adv ? carry_mo : (adj_adv && (adj_sel == DIG_MIN_TENS));
        rollover_d = run_adv & carry_mt;
    end

    mod_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clr_p), .en(en_so), .value(sec_ones), .carry(carry_so)
    );
    mod_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clr_p), .en(en_st), .value(sec_tens), .carry(carry_st)
    );
    mod_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clr_p), .en(en_mo), .value(min_ones), .carry(carry_mo)
    );
    mod_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clr_p), .en(en_mt), .value(min_tens), .carry(carry_mt)
    );

    assign running  = (state_q == ST_RUN);
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with hand-computed expectations.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_p;
    logic       clr_p;
    logic       adj;
    logic [1:0] adj_sel;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running;
    logic       rollover;

    int testsRun  = 0;
    int failCount = 0;
    int rollCount = 0;

    logic [15:0] digits;
    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    stopwatch_counter #(
        .SEC_TENS_MAX(4'd5),
        .MIN_TENS_MAX(4'd5),
        .START_RUNNING(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_p(pause_p), .clr_p(clr_p),
        .adj(adj), .adj_sel(adj_sel),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .rollover(rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rollover is registered, so sampling on the falling edge sees each pulse once.
    always @(negedge clk) begin
        if (rollover) rollCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one-cycle pulses for a single clock edge, then return on the next falling edge.
    task automatic applyStimulus(input logic t1, input logic t2, input logic p, input logic c);
        @(negedge clk);
        tick_1hz = t1;
        tick_2hz = t2;
        pause_p  = p;
        clr_p    = c;
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause_p  = 1'b0;
        clr_p    = 1'b0;
    endtask

    task automatic adjustDigit(input logic [1:0] sel, input int n);
        adj_sel = sel;
        repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause_p  = 1'b0;
        clr_p    = 1'b0;
        adj      = 1'b0;
        adj_sel  = 2'd0;
        #3;
        checkOutput("reset_digits", 32'(digits), 32'h0000);
        checkOutput("reset_running", 32'(running), 32'd1);
        checkOutput("reset_rollover", 32'(rollover), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 75 seconds of counting
        repeat (75) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("count_75", 32'(digits), 32'h0115);
        checkOutput("count_75_running", 32'(running), 32'd1);
        checkOutput("count_75_no_rollover", 32'(rollCount), 32'd0);

        // Preload 59:58 from 01:15 through adjust mode
        @(negedge clk);
        adj = 1'b1;
        @(negedge clk);
        checkOutput("adjust_running_low", 32'(running), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("adjust_ignores_1hz", 32'(digits), 32'h0115);
        adjustDigit(2'd0, 3);
        adjustDigit(2'd1, 4);
        adjustDigit(2'd2, 8);
        adjustDigit(2'd3, 5);
        checkOutput("preload_5958", 32'(digits), 32'h5958);
        adj = 1'b0;
        @(negedge clk);
        checkOutput("resume_run", 32'(running), 32'd1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("to_5959", 32'(digits), 32'h5959);
        checkOutput("no_rollover_5959", 32'(rollover), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_0000", 32'(digits), 32'h0000);
        checkOutput("rollover_high", 32'(rollover), 32'd1);
        @(negedge clk);
        checkOutput("rollover_one_cycle", 32'(rollover), 32'd0);
        checkOutput("rollover_count", 32'(rollCount), 32'd1);

        // Pause coinciding with a tick keeps the increment
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("at_0010", 32'(digits), 32'h0010);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pause_tick_digits", 32'(digits), 32'h0011);
        checkOutput("pause_tick_running", 32'(running), 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("paused_hold", 32'(digits), 32'h0011);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("unpause", 32'(running), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pause_again", 32'(running), 32'd0);

        // Clear while paused keeps PAUSED
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_paused_digits", 32'(digits), 32'h0000);
        checkOutput("clr_paused_state", 32'(running), 32'd0);

        // Adjust sec_tens from PAUSED with pause pulses that must be ignored
        adj_sel = 2'd1;
        @(negedge clk);
        adj = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("sec_tens_step%0d", i), 32'(sec_tens), 32'(i % 6));
            checkOutput($sformatf("min_ones_step%0d", i), 32'(min_ones), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        adj = 1'b0;
        @(negedge clk);
        checkOutput("resume_paused", 32'(running), 32'd0);
        checkOutput("after_adjust_digits", 32'(digits), 32'h0010);

        // Tick while paused together with pause: no increment, back to RUN
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pause_tick_paused_digits", 32'(digits), 32'h0010);
        checkOutput("pause_tick_paused_running", 32'(running), 32'd1);

        // Build 12:34 in adjust from RUN
        @(negedge clk);
        adj = 1'b1;
        @(negedge clk);
        adjustDigit(2'd0, 4);
        adjustDigit(2'd1, 2);
        adjustDigit(2'd2, 2);
        adjustDigit(2'd3, 1);
        adj = 1'b0;
        @(negedge clk);
        checkOutput("at_1234", 32'(digits), 32'h1234);
        checkOutput("at_1234_running", 32'(running), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_tick_digits", 32'(digits), 32'h0000);
        checkOutput("clr_tick_running", 32'(running), 32'd1);

        // adj rising alongside tick_1hz suppresses the increment
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        adj      = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checkOutput("adj_rise_tick_digits", 32'(digits), 32'h0003);
        checkOutput("adj_rise_tick_state", 32'(running), 32'd0);
        adj = 1'b0;
        @(negedge clk);
        checkOutput("adj_rise_resume", 32'(running), 32'd1);

        // Asynchronous reset between clock edges
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("before_async_rst", 32'(digits), 32'h0007);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_digits", 32'(digits), 32'h0000);
        checkOutput("async_rst_rollover", 32'(rollover), 32'd0);
        checkOutput("async_rst_running", 32'(running), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
